// File: rtl/mem_stage_pkg.sv
// ============================================================================
//  Packages : rv32i_types, memfsm
//  Brief    : Shared RV32I load/store encodings and MEM-stage FSM state codes.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package rv32i_types;

  // Load width/sign selectors carried in funct3
  typedef enum logic [2:0] {
    lb  = 3'b000,
    lh  = 3'b001,
    lw  = 3'b010,
    lbu = 3'b100,
    lhu = 3'b101
  } load_funct3_t;

  // Store width selectors carried in funct3
  typedef enum logic [2:0] {
    sb = 3'b000,
    sh = 3'b001,
    sw = 3'b010
  } store_funct3_t;

endpackage

package memfsm;

  // MEM-stage state register encoding
  typedef logic [1:0] state_t;

  localparam state_t IDLE   = 2'd0;
  localparam state_t ACCESS = 2'd1;
  localparam state_t DONE   = 2'd2;

endpackage

`default_nettype wire

// File: rtl/mem_stage_if.sv
// ============================================================================
//  Interface : mem_stage_if
//  Brief     : Data-memory request/response bus between the MEM stage
//              (master) and the data memory (slave).
//  Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_stage_if;

  logic [31:0] dmem_address;
  logic        dmem_read;
  logic        dmem_write;
  logic [3:0]  dmem_mbe;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;

  modport master (
    output dmem_address,
    output dmem_read,
    output dmem_write,
    output dmem_mbe,
    output dmem_wdata,
    input  dmem_rdata,
    input  dmem_resp
  );

  modport slave (
    input  dmem_address,
    input  dmem_read,
    input  dmem_write,
    input  dmem_mbe,
    input  dmem_wdata,
    output dmem_rdata,
    output dmem_resp
  );

endinterface

`default_nettype wire

// File: rtl/mem_stage_align.sv
// ============================================================================
//  Module   : mem_align
//  Brief    : Combinational lane steering. Produces byte enables and
//             lane-aligned store data from funct3/offset, and extracts and
//             sign/zero-extends load data from the returned memory word.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_align
  import rv32i_types::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic        is_load,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [3:0]  mbe,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Byte and half selection from the returned word
  always_comb begin
    w_byte = load_word[7:0];
    case (offset)
      2'd0:    w_byte = load_word[7:0];
      2'd1:    w_byte = load_word[15:8];
      2'd2:    w_byte = load_word[23:16];
      default: w_byte = load_word[31:24];
    endcase
    w_half = offset[1] ? load_word[31:16] : load_word[15:0];
  end

  // Load extension; unknown encodings fall back to a word pass-through
  always_comb begin
    load_data = load_word;
    case (load_funct3_t'(funct3))
      lb:      load_data = {{24{w_byte[7]}}, w_byte};
      lbu:     load_data = {24'h0, w_byte};
      lh:      load_data = {{16{w_half[15]}}, w_half};
      lhu:     load_data = {16'h0, w_half};
      default: load_data = load_word;
    endcase
  end

  // Store lane placement; loads always fetch the full word
  always_comb begin
    mbe   = 4'b1111;
    wdata = 32'h0;
    if (!is_load) begin
      case (store_funct3_t'(funct3))
        sb: begin
          mbe   = 4'b0001 << offset;
          wdata = store_data << {offset, 3'b000};
        end
        sh: begin
          mbe   = 4'b0011 << {offset[1], 1'b0};
          wdata = store_data << {offset[1], 4'b0000};
        end
        default: begin
          mbe   = 4'b1111;
          wdata = store_data;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
//  Module   : mem_stage
//  Brief    : RV32I MEM pipeline stage. Issues one data-memory transaction
//             per load/store, stalls the pipeline until the response, and
//             holds extended load data for MEM/WB.
//  Config   : MEM_MISALIGN_TRAP_EN - when defined, misaligned half/word
//             accesses are not issued and are reported on mem_misalign.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage
  import rv32i_types::*;
  import memfsm::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               ex_valid,
  input  logic               mem_read,
  input  logic               mem_write,
  input  logic [2:0]         funct3,
  input  logic [31:0]        alu_out,
  input  logic [31:0]        rs2_out,
  input  logic               pipe_advance,
  input  logic               flush,
  mem_stage_if.master        dmem,
  output logic               mem_stall,
  output logic [31:0]        mem_rdata,
  output logic               mem_done,
  output logic               mem_misalign
);

  state_t      r_state;
  logic [29:0] r_addr;
  logic [3:0]  r_mbe;
  logic [31:0] r_wdata;
  logic [2:0]  r_funct3;
  logic [1:0]  r_off;
  logic        r_is_read;
  logic        r_is_write;
  logic        r_flushed;
  logic [31:0] r_rdata;

  logic        w_memop;
  logic        w_idle;
  logic        w_access;
  logic        w_trap;
  logic [2:0]  w_funct3_sel;
  logic [1:0]  w_off_sel;
  logic        w_load_sel;
  logic [3:0]  w_mbe;
  logic [31:0] w_wdata;
  logic [31:0] w_load_data;

  assign w_memop  = ex_valid & (mem_read | mem_write) & ~flush;
  assign w_idle   = (r_state == IDLE);
  assign w_access = (r_state == ACCESS);

  // In IDLE the aligner shapes the incoming store; afterwards it decodes the
  // response using the latched width and offset.
  assign w_funct3_sel = w_idle ? funct3        : r_funct3;
  assign w_off_sel    = w_idle ? alu_out[1:0]  : r_off;
  assign w_load_sel   = w_idle ? mem_read      : r_is_read;

  mem_align u_align (
    .funct3     (w_funct3_sel),
    .offset     (w_off_sel),
    .is_load    (w_load_sel),
    .store_data (rs2_out),
    .load_word  (dmem.dmem_rdata),
    .mbe        (w_mbe),
    .wdata      (w_wdata),
    .load_data  (w_load_data)
  );

`ifdef MEM_MISALIGN_TRAP_EN
  // Half accesses need an even offset, word accesses a zero offset
  always_comb begin
    w_trap = 1'b0;
    case (funct3[1:0])
      2'b01:   w_trap = alu_out[0];
      2'b10:   w_trap = |alu_out[1:0];
      default: w_trap = 1'b0;
    endcase
  end
`else
  assign w_trap = 1'b0;
`endif

  // FSM plus request/response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_addr     <= 30'h0;
      r_mbe      <= 4'h0;
      r_wdata    <= 32'h0;
      r_funct3   <= 3'h0;
      r_off      <= 2'h0;
      r_is_read  <= 1'b0;
      r_is_write <= 1'b0;
      r_flushed  <= 1'b0;
      r_rdata    <= 32'h0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_memop) begin
            r_addr     <= alu_out[31:2];
            r_mbe      <= w_mbe;
            r_wdata    <= w_wdata;
            r_funct3   <= funct3;
            r_off      <= alu_out[1:0];
            r_flushed  <= 1'b0;
            if (w_trap) begin
              // Misaligned access completes without touching the bus
              r_is_read  <= 1'b0;
              r_is_write <= 1'b0;
              r_rdata    <= 32'h0;
              r_state    <= DONE;
            end else begin
              r_is_read  <= mem_read;
              r_is_write <= mem_write & ~mem_read;
              r_state    <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (dmem.dmem_resp) begin
            r_is_read  <= 1'b0;
            r_is_write <= 1'b0;
            r_flushed  <= 1'b0;
            if (r_flushed || flush) begin
              // Squashed while in flight: let the bus finish, drop the data
              r_state <= IDLE;
            end else begin
              r_rdata <= r_is_read ? w_load_data : 32'h0;
              r_state <= DONE;
            end
          end else if (flush) begin
            r_flushed <= 1'b1;
          end
        end
        DONE: begin
          if (flush || pipe_advance) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  logic r_misalign;

  // Remember whether the access now in DONE was trapped as misaligned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_misalign <= 1'b0;
    end else if (w_idle && w_memop) begin
      r_misalign <= w_trap;
    end
  end

  assign mem_misalign = (r_state == DONE) & r_misalign;
`else
  assign mem_misalign = 1'b0;
`endif

  // Bus drive is confined to ACCESS so an abandoned request drops with reset
  assign dmem.dmem_read    = w_access & r_is_read;
  assign dmem.dmem_write   = w_access & r_is_write;
  assign dmem.dmem_address = w_access ? {r_addr, 2'b00} : 32'h0;
  assign dmem.dmem_mbe     = w_access ? r_mbe : 4'h0;
  assign dmem.dmem_wdata   = w_access ? r_wdata : 32'h0;

  assign mem_stall = (w_idle & w_memop) | w_access;
  assign mem_done  = (r_state == DONE);
  assign mem_rdata = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
//  Module   : tb_mem_stage
//  Brief    : Self-checking bench for mem_stage. Expected bus requests and
//             completions are queued by the stimulus and popped by a monitor.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage;

  typedef struct packed {
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [3:0]  mbe;
    logic [31:0] wdata;
    logic        chk_wdata;
  } req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        chk_rdata;
    logic        misalign;
  } done_t;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] alu_out;
  logic [31:0] rs2_out;
  logic        pipe_advance;
  logic        flush;
  logic        mem_stall;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        mem_misalign;

  mem_stage_if dif ();

  mem_stage dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .funct3       (funct3),
    .alu_out      (alu_out),
    .rs2_out      (rs2_out),
    .pipe_advance (pipe_advance),
    .flush        (flush),
    .dmem         (dif.master),
    .mem_stall    (mem_stall),
    .mem_rdata    (mem_rdata),
    .mem_done     (mem_done),
    .mem_misalign (mem_misalign)
  );

  int checks = 0;
  int errors = 0;
  int req_count = 0;
  req_t  req_q[$];
  done_t done_q[$];
  logic prev_req = 1'b0;
  logic prev_done = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, act, exp);
    end
  endtask

  // Monitor: compare each new bus request and each new completion
  always @(negedge clk) begin
    req_t  r;
    done_t d;
    if (rst) begin
      prev_req  = 1'b0;
      prev_done = 1'b0;
    end else begin
      if ((dif.dmem_read || dif.dmem_write) && !prev_req) begin
        req_count++;
        checks++;
        if (req_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_req addr=%h rd=%b wr=%b", dif.dmem_address, dif.dmem_read, dif.dmem_write);
        end else begin
          r = req_q.pop_front();
          if (dif.dmem_address !== r.addr || dif.dmem_read !== r.rd || dif.dmem_write !== r.wr ||
              dif.dmem_mbe !== r.mbe || (r.chk_wdata && dif.dmem_wdata !== r.wdata)) begin
            errors++;
            $display("FAIL req got addr=%h rd=%b wr=%b mbe=%b wdata=%h exp addr=%h rd=%b wr=%b mbe=%b wdata=%h",
                     dif.dmem_address, dif.dmem_read, dif.dmem_write, dif.dmem_mbe, dif.dmem_wdata,
                     r.addr, r.rd, r.wr, r.mbe, r.wdata);
          end
        end
      end
      prev_req = dif.dmem_read | dif.dmem_write;
      if (mem_done && !prev_done) begin
        checks++;
        if (done_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done rdata=%h", mem_rdata);
        end else begin
          d = done_q.pop_front();
          if ((d.chk_rdata && mem_rdata !== d.rdata) || mem_misalign !== d.misalign || mem_stall !== 1'b0) begin
            errors++;
            $display("FAIL done got rdata=%h misalign=%b stall=%b exp rdata=%h misalign=%b stall=0",
                     mem_rdata, mem_misalign, mem_stall, d.rdata, d.misalign);
          end
        end
      end
      prev_done = mem_done;
    end
  end

  task automatic issue(input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    ex_valid  = 1'b1;
    mem_read  = rd;
    mem_write = wr;
    funct3    = f3;
    alu_out   = a;
    rs2_out   = d;
  endtask

  // Runs n+3 cycles from the issue cycle, pulsing resp in cycle n
  task automatic run_op(input int n, input logic [31:0] rdata,
                        output int stalls, output bit stable);
    logic [69:0] snap;
    logic [69:0] cur;
    bit have;
    have   = 1'b0;
    snap   = '0;
    stalls = 0;
    stable = 1'b1;
    for (int k = 0; k < n + 3; k++) begin
      if (k == n) begin
        dif.dmem_rdata = rdata;
        dif.dmem_resp  = 1'b1;
      end
      @(negedge clk);
      if (mem_stall) stalls++;
      if (dif.dmem_read || dif.dmem_write) begin
        cur = {dif.dmem_address, dif.dmem_read, dif.dmem_write, dif.dmem_mbe, dif.dmem_wdata};
        if (!have) begin
          snap = cur;
          have = 1'b1;
        end else if (cur !== snap) begin
          stable = 1'b0;
        end
      end
      @(posedge clk); #1;
      dif.dmem_resp  = 1'b0;
      dif.dmem_rdata = 32'h0;
    end
  endtask

  task automatic retire();
    @(posedge clk); #1;
    pipe_advance = 1'b1;
    ex_valid     = 1'b0;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    @(posedge clk); #1;
    pipe_advance = 1'b0;
  endtask

  initial begin
    int stalls;
    bit stable;
    int rc;
    rst = 1'b1; ex_valid = 0; mem_read = 0; mem_write = 0; funct3 = 0;
    alu_out = 0; rs2_out = 0; pipe_advance = 0; flush = 0;
    dif.dmem_rdata = 0; dif.dmem_resp = 0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_addr", dif.dmem_address, 32'h0);
    chk("rst_wdata", dif.dmem_wdata, 32'h0);
    chk("rst_rdata", mem_rdata, 32'h0);
    chk("rst_ctl", {23'h0, dif.dmem_read, dif.dmem_write, dif.dmem_mbe, mem_stall, mem_done, mem_misalign}, 32'h0);
    @(posedge clk); #1; rst = 1'b0;

    // LW 0x100, response two cycles after issue
    issue(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    req_q.push_back('{32'h100, 1'b1, 1'b0, 4'b1111, 32'h0, 1'b0});
    done_q.push_back('{32'hDEADBEEF, 1'b1, 1'b0});
    run_op(2, 32'hDEADBEEF, stalls, stable);
    chk("lw_stall", stalls, 3);
    chk("lw_stable", {31'h0, stable}, 1);
    chk("lw_rdata", mem_rdata, 32'hDEADBEEF);
    retire();

    // LB / LBU at 0x103
    issue(1'b1, 1'b0, 3'b000, 32'h103, 32'h0);
    req_q.push_back('{32'h100, 1'b1, 1'b0, 4'b1111, 32'h0, 1'b0});
    done_q.push_back('{32'hFFFFFF80, 1'b1, 1'b0});
    run_op(1, 32'h80FF_0000, stalls, stable);
    chk("lb_stall", stalls, 2);
    retire();
    issue(1'b1, 1'b0, 3'b100, 32'h103, 32'h0);
    req_q.push_back('{32'h100, 1'b1, 1'b0, 4'b1111, 32'h0, 1'b0});
    done_q.push_back('{32'h00000080, 1'b1, 1'b0});
    run_op(1, 32'h80FF_0000, stalls, stable);
    retire();

    // SH 0x202, write held for a slow response
    issue(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD);
    req_q.push_back('{32'h200, 1'b0, 1'b1, 4'b1100, 32'hABCD0000, 1'b1});
    done_q.push_back('{32'h0, 1'b0, 1'b0});
    run_op(3, 32'h0, stalls, stable);
    chk("sh_stall", stalls, 4);
    chk("sh_stable", {31'h0, stable}, 1);
    retire();

    // SB 0x401 and SW 0x500 lanes
    issue(1'b0, 1'b1, 3'b000, 32'h401, 32'h000000A5);
    req_q.push_back('{32'h400, 1'b0, 1'b1, 4'b0010, 32'h0000A500, 1'b1});
    done_q.push_back('{32'h0, 1'b0, 1'b0});
    run_op(1, 32'h0, stalls, stable);
    retire();
    issue(1'b0, 1'b1, 3'b010, 32'h500, 32'hCAFEF00D);
    req_q.push_back('{32'h500, 1'b0, 1'b1, 4'b1111, 32'hCAFEF00D, 1'b1});
    done_q.push_back('{32'h0, 1'b0, 1'b0});
    run_op(1, 32'h0, stalls, stable);
    retire();

    // Read and write both set behaves as a load
    issue(1'b1, 1'b1, 3'b010, 32'h800, 32'hFFFFFFFF);
    req_q.push_back('{32'h800, 1'b1, 1'b0, 4'b1111, 32'h0, 1'b0});
    done_q.push_back('{32'h13572468, 1'b1, 1'b0});
    run_op(1, 32'h13572468, stalls, stable);
    retire();

    // LH 0x302 held in DONE while pipe_advance stays low
    rc = req_count;
    issue(1'b1, 1'b0, 3'b001, 32'h302, 32'h0);
    req_q.push_back('{32'h300, 1'b1, 1'b0, 4'b1111, 32'h0, 1'b0});
    done_q.push_back('{32'hFFFF8001, 1'b1, 1'b0});
    run_op(1, 32'h80011234, stalls, stable);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("hold_done", {31'h0, mem_done}, 1);
      chk("hold_rdata", mem_rdata, 32'hFFFF8001);
    end
    chk("hold_single_req", req_count - rc, 1);
    retire();

    // Non-memory instruction passes with no stall; stray resp is ignored
    @(posedge clk); #1;
    ex_valid = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    dif.dmem_resp = 1'b1;
    @(negedge clk);
    chk("nonmem_stall", {31'h0, mem_stall}, 0);
    @(posedge clk); #1; dif.dmem_resp = 1'b0;
    @(negedge clk);
    chk("stray_resp_done", {31'h0, mem_done}, 0);
    @(posedge clk); #1; ex_valid = 1'b0;

    // Flush while in ACCESS: bus finishes, no completion
    issue(1'b1, 1'b0, 3'b010, 32'h600, 32'h0);
    req_q.push_back('{32'h600, 1'b1, 1'b0, 4'b1111, 32'h0, 1'b0});
    @(posedge clk); #1;
    flush = 1'b1; ex_valid = 1'b0; mem_read = 1'b0;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_keeps_req", {31'h0, dif.dmem_read}, 1);
    @(posedge clk); #1; dif.dmem_rdata = 32'h55AA55AA; dif.dmem_resp = 1'b1;
    @(posedge clk); #1; dif.dmem_resp = 1'b0; dif.dmem_rdata = 32'h0;
    @(negedge clk);
    chk("flush_idle", {30'h0, mem_stall, dif.dmem_read}, 0);
    repeat (2) @(negedge clk);
    chk("flush_no_done", {31'h0, mem_done}, 0);

    // Reset mid-ACCESS drops the request immediately
    issue(1'b1, 1'b0, 3'b010, 32'h700, 32'h0);
    req_q.push_back('{32'h700, 1'b1, 1'b0, 4'b1111, 32'h0, 1'b0});
    @(posedge clk); #1;
    ex_valid = 1'b0; mem_read = 1'b0;
    @(negedge clk);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_read", {31'h0, dif.dmem_read}, 0);
    chk("arst_addr", dif.dmem_address, 32'h0);
    chk("arst_outs", {27'h0, mem_stall, mem_done, mem_misalign, dif.dmem_write, |dif.dmem_mbe}, 32'h0);
    chk("arst_rdata", mem_rdata, 32'h0);
    #1; rst = 1'b0;

    // LW at 0x101: trapped when the misalign feature is built in
    issue(1'b1, 1'b0, 3'b010, 32'h101, 32'h0);
`ifdef MEM_MISALIGN_TRAP_EN
    done_q.push_back('{32'h0, 1'b1, 1'b1});
    run_op(1, 32'h0BADF00D, stalls, stable);
    chk("misalign_stall", stalls, 1);
`else
    req_q.push_back('{32'h100, 1'b1, 1'b0, 4'b1111, 32'h0, 1'b0});
    done_q.push_back('{32'h0BADF00D, 1'b1, 1'b0});
    run_op(1, 32'h0BADF00D, stalls, stable);
    chk("misalign_stall", stalls, 2);
`endif
    retire();
    repeat (2) @(negedge clk);

    chk("req_q_drained", req_q.size(), 0);
    chk("done_q_drained", done_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
